// File: rtl/id_stage_pkg.sv
// Shared decode constants for the instruction-decode stage: opcodes, ALUOp
// encodings, control-vector layout and ID/EX latch field positions.
package id_stage_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned CTRL_W   = 10;
  localparam int unsigned ALUOP_W  = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // ID/EX latch layout for the 32-bit configuration (LSB offsets and widths)
  localparam int unsigned ID_EX_IMM_LSB  = 0;
  localparam int unsigned ID_EX_IMM_W    = 32;
  localparam int unsigned ID_EX_RT_LSB   = 32;
  localparam int unsigned ID_EX_RT_W     = 32;
  localparam int unsigned ID_EX_RS_LSB   = 64;
  localparam int unsigned ID_EX_RS_W     = 32;
  localparam int unsigned ID_EX_CTRL_LSB = 96;
  localparam int unsigned ID_EX_CTRL_W   = CTRL_W;
  localparam int unsigned ID_EX_PC4_LSB  = 106;
  localparam int unsigned ID_EX_PC4_W    = 32;
  localparam int unsigned ID_EX_WREG_LSB = 138;
  localparam int unsigned ID_EX_WREG_W   = 5;
  localparam int unsigned ID_EX_W        = 143;

  // Member order matches the control bit order, RegDst at the MSB
  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] alu_op;
    logic               jump;
  } ctrl_t;

endpackage

// File: rtl/id_stage_control_unit.sv
// Main decoder: maps the opcode to the 10-bit pipeline control vector.
// Unrecognised opcodes produce an all-zero vector (bubble).
module control_unit
  import id_stage_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_t               ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      OP_J: begin
        ctrl_o.jump = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes the IF/ID latch, reads operands, sign-extends
// the immediate and registers the result into the ID/EX latch every cycle.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [2*SIZE-1:0]                    IF_ID,
  input  logic [SIZE-1:0][SIZE-1:0]            registerFile,
  output logic [$clog2(SIZE)+10+4*SIZE-1:0]    ID_EX
);

  localparam int unsigned REG_W  = $clog2(SIZE);
  localparam int unsigned OUT_W  = REG_W + CTRL_W + 4*SIZE;

  logic [SIZE-1:0]     pc4;
  logic [SIZE-1:0]     instr;
  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0]    rs_idx;
  logic [REG_W-1:0]    rt_idx;
  logic [REG_W-1:0]    rd_idx;
  logic [REG_W-1:0]    wreg;
  logic [SIZE-1:0]     rs_data;
  logic [SIZE-1:0]     rt_data;
  logic [SIZE-1:0]     imm_ext;
  ctrl_t               ctrl;
  logic [OUT_W-1:0]    id_ex_d;
  logic [OUT_W-1:0]    id_ex_q;

  assign pc4    = IF_ID[2*SIZE-1:SIZE];
  assign instr  = IF_ID[SIZE-1:0];
  assign opcode = instr[31:26];
  assign rs_idx = REG_W'(instr[25:21]);
  assign rt_idx = REG_W'(instr[20:16]);
  assign rd_idx = REG_W'(instr[15:11]);

  control_unit u_control_unit (
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

  // Register 0 is hard-wired to zero whatever the array holds
  always_comb begin
    rs_data = (rs_idx == '0) ? '0 : registerFile[rs_idx];
    rt_data = (rt_idx == '0) ? '0 : registerFile[rt_idx];
  end

  assign imm_ext = {{(SIZE-16){instr[15]}}, instr[15:0]};
  assign wreg    = ctrl.reg_dst ? rd_idx : rt_idx;
  assign id_ex_d = {wreg, pc4, ctrl, rs_data, rt_data, imm_ext};

  // ID/EX latch: async clear to a bubble, loads unconditionally otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign ID_EX = id_ex_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed vector table, reset sequences and
// randomized decode checked against a behavioural model.
module tb_id_stage;

  logic               clk;
  logic               rst_n;
  logic [63:0]        if_id;
  logic [31:0][31:0]  rf;
  logic [142:0]       id_ex;

  int unsigned n_vec;
  int unsigned n_err;

  id_stage #(.SIZE(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IF_ID        (if_id),
    .registerFile (rf),
    .ID_EX        (id_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [4:0]  wreg;
    logic [9:0]  ctrl;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
  } vec_t;

  task automatic check(input string name, input logic [142:0] exp);
    n_vec++;
    if (id_ex !== exp) begin
      n_err++;
      $display("FAIL %s: ID_EX got %h expected %h", name, id_ex, exp);
    end
  endtask

  // Reference decode computed from the field rules with plain arithmetic
  function automatic logic [142:0] model(input logic [63:0] ifid,
                                         input logic [31:0][31:0] regs);
    int unsigned ins, op, rs, rt, rd, imm16, immx, wr;
    logic [9:0]  c;
    logic [31:0] rsd, rtd;
    ins   = ifid[31:0];
    op    = ins >> 26;
    rs    = (ins >> 21) % 32;
    rt    = (ins >> 16) % 32;
    rd    = (ins >> 11) % 32;
    imm16 = ins % 65536;
    immx  = (imm16 >= 32768) ? imm16 + 32'hFFFF_0000 : imm16;
    case (op)
      0:       c = 10'b1001000100;
      35:      c = 10'b0111100000;
      43:      c = 10'b0100010000;
      4:       c = 10'b0000001010;
      8:       c = 10'b0101000000;
      2:       c = 10'b0000000001;
      default: c = 10'b0000000000;
    endcase
    wr  = c[9] ? rd : rt;
    rsd = (rs == 0) ? 32'd0 : regs[rs];
    rtd = (rt == 0) ? 32'd0 : regs[rt];
    return {5'(wr), ifid[63:32], c, rsd, rtd, 32'(immx)};
  endfunction

  vec_t vecs[8];
  logic [142:0] exp_v;
  logic [5:0]   ops[7];

  initial begin
    n_vec = 0;
    n_err = 0;

    vecs[0] = '{"rtype",   32'h0086_4010, 32'd4,        5'd8,  10'b1001000100, 32'd4,  32'd6,  32'h0000_4010};
    vecs[1] = '{"lw",      32'h8C45_FFFC, 32'h100,      5'd5,  10'b0111100000, 32'd2,  32'd5,  32'hFFFF_FFFC};
    vecs[2] = '{"sw",      32'hAC67_0008, 32'h104,      5'd7,  10'b0100010000, 32'd3,  32'd7,  32'h0000_0008};
    vecs[3] = '{"beq_r0",  32'h1003_8000, 32'h108,      5'd3,  10'b0000001010, 32'd0,  32'd3,  32'hFFFF_8000};
    vecs[4] = '{"addi",    32'h212A_7FFF, 32'h10C,      5'd10, 10'b0101000000, 32'd9,  32'd10, 32'h0000_7FFF};
    vecs[5] = '{"j",       32'h0800_0040, 32'h110,      5'd0,  10'b0000000001, 32'd0,  32'd0,  32'h0000_0040};
    vecs[6] = '{"unknown", 32'hFFE1_FFFF, 32'hCAFE_0004, 5'd1, 10'b0000000000, 32'd31, 32'd1,  32'hFFFF_FFFF};
    vecs[7] = '{"rtype31", 32'h03FF_0000, 32'h8000_0000, 5'd0, 10'b1001000100, 32'd31, 32'd31, 32'h0000_0000};

    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    rf[0] = 32'h0000_DEAD;

    // Reset: immediate clear and no loading while asserted
    rst_n = 1'b0;
    if_id = {$urandom, $urandom};
    #1 check("reset_immediate", '0);
    repeat (3) @(posedge clk);
    #1 check("reset_hold_edges", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_release_no_edge", '0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if_id = {vecs[i].pc4, vecs[i].instr};
      @(posedge clk);
      #1 check(vecs[i].name, {vecs[i].wreg, vecs[i].pc4, vecs[i].ctrl,
                              vecs[i].rs_d, vecs[i].rt_d, vecs[i].imm});
    end

    // Output holds between edges when inputs change
    exp_v = {vecs[7].wreg, vecs[7].pc4, vecs[7].ctrl, vecs[7].rs_d, vecs[7].rt_d, vecs[7].imm};
    @(negedge clk);
    if_id = {vecs[1].pc4, vecs[1].instr};
    rf[31] = 32'h1234_5678;
    #1 check("hold_between_edges", exp_v);
    rf[31] = 32'd31;

    // Reset pulse mid-cycle discards the in-flight decode
    @(negedge clk);
    if_id = {vecs[0].pc4, vecs[0].instr};
    @(posedge clk);
    #1 check("pre_reset_load", {vecs[0].wreg, vecs[0].pc4, vecs[0].ctrl,
                                vecs[0].rs_d, vecs[0].rt_d, vecs[0].imm});
    #2 rst_n = 1'b0;
    #1 check("midcycle_async_clear", '0);
    @(posedge clk);
    #1 check("midcycle_reset_edge", '0);
    @(negedge clk);
    rst_n = 1'b1;
    if_id = {vecs[6].pc4, vecs[6].instr};
    #1 check("midcycle_release", '0);
    @(posedge clk);
    #1 check("post_reset_unknown", {vecs[6].wreg, vecs[6].pc4, vecs[6].ctrl,
                                    vecs[6].rs_d, vecs[6].rt_d, vecs[6].imm});

    // Randomized decode against the model
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b111111;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ins;
      @(negedge clk);
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31:26] = ops[$urandom_range(0, 6)];
      if_id = {32'($urandom), ins};
      exp_v = model(if_id, rf);
      @(posedge clk);
      #1 check("random", exp_v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter SIZE, default 32, data/register width and register count; only SIZE=32 is required to be supported.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 IF_ID  input  2*SIZE (64)  IF/ID latch: [63:32] = PC+4, [31:0] = instruction word.
REQ-005 registerFile  input  SIZE x SIZE packed array ([31:0][31:0])  current architectural register contents, entry i = register i.
REQ-006 ID_EX  output  $clog2(SIZE)+10+4*SIZE (143)  registered ID/EX latch.

Function
REQ-007 ID_EX field map, MSB to LSB, SHALL be: [142:138] write-register number, [137:106] PC+4, [105:96] control, [95:64] rs data, [63:32] rt data, [31:0] sign-extended immediate.
REQ-008 Instruction fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], immediate [15:0].
REQ-009 Control bit order in [105:96]: RegDst 105, ALUSrc 104, MemtoReg 103, RegWrite 102, MemRead 101, MemWrite 100, Branch 99, ALUOp 98:97, Jump 96.
REQ-010 Decode: opcode 000000 (R-type) -> RegDst=1, RegWrite=1, ALUOp=10, others 0.
REQ-011 opcode 100011 (lw) -> ALUSrc, MemtoReg, RegWrite, MemRead =1, ALUOp=00.
REQ-012 opcode 101011 (sw) -> ALUSrc, MemWrite =1, ALUOp=00.
REQ-013 opcode 000100 (beq) -> Branch=1, ALUOp=01.
REQ-014 opcode 001000 (addi) -> ALUSrc, RegWrite =1, ALUOp=00.
REQ-015 opcode 000010 (j) -> Jump=1, all others 0.
REQ-016 Any other opcode -> all 10 control bits 0 (bubble); remaining fields still populated.
REQ-017 Write register = rd when RegDst=1, else rt.
REQ-018 rs/rt data = registerFile[rs]/registerFile[rt], read combinationally; register 0 SHALL read as 0 regardless of array contents.
REQ-019 Immediate = {16{instr[15]}, instr[15:0]}.
REQ-020 PC+4 copied unchanged from IF_ID[63:32].
REQ-021 Latency: ID_EX reflects the IF_ID/registerFile values sampled at a rising clk edge, one cycle; ID_EX holds between edges.
REQ-022 No stall/flush inputs; ID_EX loads every cycle.

Reset
REQ-023 rst_n low SHALL immediately clear ID_EX to all zeros (bubble), independent of clk.
REQ-024 While rst_n low, clk edges SHALL not load ID_EX; first load occurs at the first rising edge after rst_n deasserts.
REQ-025 Reset asserted mid-operation discards the in-flight decode; no partial fields retained.

Structure
REQ-026 Shared package SHALL hold opcode constants (R-type, lw, sw, beq, addi, j), ALUOp encodings, and ID_EX field offset/width constants.
REQ-027 One sub-module control_unit: opcode in, 10-bit control vector out, purely combinational.
REQ-028 Operand read, sign extension and write-register mux live in id_stage; single always block for the ID_EX register.

Verification
REQ-029 Reset: rst_n=0 with arbitrary IF_ID -> ID_EX=0 immediately, stays 0 across clk edges.
REQ-030 R-type: registerFile[i]=i, IF_ID={32'd4, 000000_00100_00110_01000_00000_010000}, one edge -> write reg 8, PC+4=4, control 10'b1001000100, rs=4, rt=6, imm=0x00004010.
REQ-031 lw: opcode 100011, rs=2, rt=5, imm=0xFFFC -> write reg 5, control 10'b0111100000, rs=2, imm=0xFFFFFFFC.
REQ-032 beq rs=0, rt=3 with registerFile[0]=0xDEAD -> rs data 0, control 10'b0000001010.
REQ-033 Unknown opcode 111111 -> control 0, other fields populated; async reset pulse mid-cycle then release -> 0 until next edge, then correct decode.
